sobel_edge_pipe: RTL and testbench

//  Parametrised Sobel/Prewitt edge detector for the streaming video path, placed after the
//  RGB->Y conversion stage. Builds a 3x3 window from the Y stream, computes the gradient

---
 rtl/sobel_pkg.sv | 16 +
 rtl/window_3x3_gen.sv | 69 ++++++
 rtl/sobel_edge_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_sobel_edge_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel/Prewitt edge pipeline.
package sobel_pkg;

  // Kernel select: Sobel weights the centre tap of each side by 2, Prewitt by 1.
  localparam logic OP_SOBEL   = 1'b0;
  localparam logic OP_PREWITT = 1'b1;

  // Magnitude select: L1 sum of the two gradients or the larger of the two.
  localparam logic MAG_L1  = 1'b0;
  localparam logic MAG_MAX = 1'b1;

  // Input-to-output latency in pixel clocks, and edge counter width.
  localparam int unsigned LAT   = 4;
  localparam int unsigned CNT_W = 20;

endpackage

// File: rtl/window_3x3_gen.sv
// 3x3 sliding window over a raster luma stream. The right-hand column comes straight from
// the input pixel and the two line-buffer reads, so the window adds no latency of its own.
module window_3x3_gen #(
  parameter int unsigned DW     = 8,
  parameter int unsigned H_DISP = 640,
  parameter int unsigned AW     = $clog2(H_DISP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] matrix_11,
  output logic [DW-1:0] matrix_12,
  output logic [DW-1:0] matrix_13,
  output logic [DW-1:0] matrix_21,
  output logic [DW-1:0] matrix_22,
  output logic [DW-1:0] matrix_23,
  output logic [DW-1:0] matrix_31,
  output logic [DW-1:0] matrix_32,
  output logic [DW-1:0] matrix_33
);

  logic [DW-1:0] lb1_mem [H_DISP];
  logic [DW-1:0] lb2_mem [H_DISP];
  logic [DW-1:0] lb1_rd, lb2_rd;
  logic [DW-1:0] m11_q, m12_q, m21_q, m22_q, m31_q, m32_q;

  assign lb1_rd = lb1_mem[addr];
  assign lb2_rd = lb2_mem[addr];

  // Line buffers: each valid pixel pushes its column one line further up.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      lb1_mem[addr] <= din;
      lb2_mem[addr] <= lb1_rd;
    end
  end

  // Tap registers hold the two older window columns; they only move on valid pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m11_q <= '0;
      m12_q <= '0;
      m21_q <= '0;
      m22_q <= '0;
      m31_q <= '0;
      m32_q <= '0;
    end else if (din_vld) begin
      m11_q <= m12_q;
      m12_q <= lb2_rd;
      m21_q <= m22_q;
      m22_q <= lb1_rd;
      m31_q <= m32_q;
      m32_q <= din;
    end
  end

  assign matrix_11 = m11_q;
  assign matrix_12 = m12_q;
  assign matrix_13 = lb2_rd;
  assign matrix_21 = m21_q;
  assign matrix_22 = m22_q;
  assign matrix_23 = lb1_rd;
  assign matrix_31 = m31_q;
  assign matrix_32 = m32_q;
  assign matrix_33 = din;

endmodule

// File: rtl/sobel_edge_pipe.sv
// Streaming Sobel/Prewitt edge detector: 3x3 window, 4-stage gradient pipeline, threshold,
// border suppression, sync delay and a per-frame edge-pixel counter.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned H_DISP = 640,
  parameter int unsigned V_DISP = 480,
  parameter bit          FG     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Y_de,
  input  logic             Y_hsync,
  input  logic             Y_vsync,
  input  logic [DW-1:0]    Y_data,
  input  logic [DW+2:0]    value,
  input  logic             op_sel,
  input  logic             mag_sel,
  output logic             sobel_de,
  output logic             sobel_hsync,
  output logic             sobel_vsync,
  output logic [DW-1:0]    sobel_data,
  output logic [DW+2:0]    sobel_mag,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int unsigned   AW     = $clog2(H_DISP);
  localparam int unsigned   RW     = $clog2(V_DISP);
  localparam int unsigned   SW     = DW + 2;
  localparam int unsigned   MW     = DW + 3;
  localparam logic [AW-1:0] ColMax = AW'(H_DISP - 1);
  localparam logic [RW-1:0] RowMax = RW'(V_DISP - 1);
  localparam logic [DW-1:0] FgPat  = {DW{FG}};

  logic de_prev_q, vs_prev_q, de_fall, vs_rise;
  logic [AW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [MW-1:0] thr_sh_q;
  logic op_sh_q, msel_sh_q;
  logic in_vld;

  logic [DW-1:0] w11, w12, w13, w21, w22, w23, w31, w32, w33;
  logic unused_center;

  logic prewitt;
  logic s1_vld_q, s2_vld_q, s3_vld_q;
  logic [SW-1:0] s1_l_d, s1_r_d, s1_t_d, s1_b_d, s1_l_q, s1_r_q, s1_t_q, s1_b_q;
  logic [SW-1:0] s2_gx_d, s2_gy_d, s2_gx_q, s2_gy_q;
  logic [MW-1:0] s3_mag_d, s3_mag_q;
  logic edge_d, edge_q;
  logic [DW-1:0] data_d, data_q;
  logic [MW-1:0] omag_d, omag_q;

  logic [LAT-1:0] de_sr_q, hs_sr_q, vs_sr_q;
  logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;

  assign de_fall = de_prev_q & ~Y_de;
  assign vs_rise = Y_vsync & ~vs_prev_q;
  // Window positions whose 3x3 neighbourhood reaches off-frame are suppressed.
  assign in_vld  = Y_de && (row_q >= RW'(2)) && (col_q >= AW'(2));

  window_3x3_gen #(
    .DW    (DW),
    .H_DISP(H_DISP),
    .AW    (AW)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .din_vld  (Y_de),
    .din      (Y_data),
    .addr     (col_q),
    .matrix_11(w11),
    .matrix_12(w12),
    .matrix_13(w13),
    .matrix_21(w21),
    .matrix_22(w22),
    .matrix_23(w23),
    .matrix_31(w31),
    .matrix_32(w32),
    .matrix_33(w33)
  );

  // Neither kernel uses the centre tap.
  assign unused_center = ^w22;

  function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c, input logic pw);
    logic [SW-1:0] mid;
    mid = pw ? {2'b00, b} : {1'b0, b, 1'b0};
    return {2'b00, a} + mid + {2'b00, c};
  endfunction

  // Column/row counters; both saturate so malformed timing cannot wrap them.
  always_comb begin
    col_d = col_q;
    if (Y_de) begin
      if (col_q != ColMax) col_d = col_q + AW'(1);
    end else if (de_fall) begin
      col_d = '0;
    end
    row_d = row_q;
    if (vs_rise) begin
      row_d = '0;
    end else if (de_fall && (row_q != RowMax)) begin
      row_d = row_q + RW'(1);
    end
  end

  // Counters, edge detectors and the per-frame mode/threshold shadows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      thr_sh_q  <= '0;
      op_sh_q   <= OP_SOBEL;
      msel_sh_q <= MAG_L1;
    end else begin
      de_prev_q <= Y_de;
      vs_prev_q <= Y_vsync;
      col_q     <= col_d;
      row_q     <= row_d;
      if (vs_rise) begin
        thr_sh_q  <= value;
        op_sh_q   <= op_sel;
        msel_sh_q <= mag_sel;
      end
    end
  end

  // Pipeline next-state: side sums, absolute differences, magnitude, threshold.
  always_comb begin
    prewitt  = (op_sh_q == OP_PREWITT);
    s1_l_d   = wsum(w11, w21, w31, prewitt);
    s1_r_d   = wsum(w13, w23, w33, prewitt);
    s1_t_d   = wsum(w11, w12, w13, prewitt);
    s1_b_d   = wsum(w31, w32, w33, prewitt);
    s2_gx_d  = (s1_r_q >= s1_l_q) ? (s1_r_q - s1_l_q) : (s1_l_q - s1_r_q);
    s2_gy_d  = (s1_b_q >= s1_t_q) ? (s1_b_q - s1_t_q) : (s1_t_q - s1_b_q);
    if (msel_sh_q == MAG_MAX) begin
      s3_mag_d = {1'b0, (s2_gx_q >= s2_gy_q) ? s2_gx_q : s2_gy_q};
    end else begin
      s3_mag_d = {1'b0, s2_gx_q} + {1'b0, s2_gy_q};
    end
    edge_d = s3_vld_q && (s3_mag_q > thr_sh_q);
    data_d = edge_d ? FgPat : ~FgPat;
    omag_d = s3_vld_q ? s3_mag_q : '0;
  end

  // Four arithmetic stages; the valid flag carries data-enable and border together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_l_q   <= '0;
      s1_r_q   <= '0;
      s1_t_q   <= '0;
      s1_b_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_gx_q  <= '0;
      s2_gy_q  <= '0;
      s3_vld_q <= 1'b0;
      s3_mag_q <= '0;
      edge_q   <= 1'b0;
      data_q   <= '0;
      omag_q   <= '0;
    end else begin
      s1_vld_q <= in_vld;
      s1_l_q   <= s1_l_d;
      s1_r_q   <= s1_r_d;
      s1_t_q   <= s1_t_d;
      s1_b_q   <= s1_b_d;
      s2_vld_q <= s1_vld_q;
      s2_gx_q  <= s2_gx_d;
      s2_gy_q  <= s2_gy_d;
      s3_vld_q <= s2_vld_q;
      s3_mag_q <= s3_mag_d;
      edge_q   <= edge_d;
      data_q   <= data_d;
      omag_q   <= omag_d;
    end
  end

  // Sync delay lines matching the arithmetic latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_sr_q <= '0;
      hs_sr_q <= '0;
      vs_sr_q <= '0;
    end else begin
      de_sr_q <= {de_sr_q[LAT-2:0], Y_de};
      hs_sr_q <= {hs_sr_q[LAT-2:0], Y_hsync};
      vs_sr_q <= {vs_sr_q[LAT-2:0], Y_vsync};
    end
  end

  // Edge accumulator; an edge coinciding with the frame boundary belongs to the new frame.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (vs_rise) begin
      cnt_d = acc_q;
      acc_d = CNT_W'(edge_q);
    end else if (edge_q && (acc_q != '1)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  // Edge accumulator and published count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign sobel_de    = de_sr_q[LAT-1];
  assign sobel_hsync = hs_sr_q[LAT-1];
  assign sobel_vsync = vs_sr_q[LAT-1];
  assign sobel_data  = data_q;
  assign sobel_mag   = omag_q;
  assign edge_cnt    = cnt_q;

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Bench for sobel_edge_pipe on a 16x8 frame with a pixel-level reference model.
module tb_sobel_edge_pipe;

  localparam int unsigned DW  = 8;
  localparam int unsigned H   = 16;
  localparam int unsigned V   = 8;
  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic Y_de, Y_hsync, Y_vsync;
  logic [DW-1:0] Y_data;
  logic [DW+2:0] value;
  logic op_sel, mag_sel;
  logic sobel_de, sobel_hsync, sobel_vsync;
  logic [DW-1:0] sobel_data;
  logic [DW+2:0] sobel_mag;
  logic [19:0] edge_cnt;

  always #5 clk = ~clk;

  sobel_edge_pipe #(
    .DW    (DW),
    .H_DISP(H),
    .V_DISP(V),
    .FG    (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Y_de       (Y_de),
    .Y_hsync    (Y_hsync),
    .Y_vsync    (Y_vsync),
    .Y_data     (Y_data),
    .value      (value),
    .op_sel     (op_sel),
    .mag_sel    (mag_sel),
    .sobel_de   (sobel_de),
    .sobel_hsync(sobel_hsync),
    .sobel_vsync(sobel_vsync),
    .sobel_data (sobel_data),
    .sobel_mag  (sobel_mag),
    .edge_cnt   (edge_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] img [V][H];
  int exp_mag [V][H];
  bit exp_edge [V][H];
  int got_mag [V][H];
  int prev_exp = 0;
  logic [2:0] hist [$];
  logic [7:0] cap_data [$];
  logic [10:0] cap_mag [$];

  // Reference: direct 3x3 convolution on the stored image, border positions forced off.
  function automatic int model_frame(input int thr, input bit op, input bit ms);
    int k[3];
    int gx, gy, ax, ay, g, n;
    k[0] = 1;
    k[1] = op ? 1 : 2;
    k[2] = 1;
    n = 0;
    for (int r = 0; r < int'(V); r++) begin
      for (int c = 0; c < int'(H); c++) begin
        if (r < 2 || c < 2) begin
          exp_mag[r][c]  = 0;
          exp_edge[r][c] = 1'b0;
        end else begin
          gx = 0;
          gy = 0;
          for (int i = 0; i < 3; i++) begin
            gx += k[i] * (int'(img[r-2+i][c]) - int'(img[r-2+i][c-2]));
            gy += k[i] * (int'(img[r][c-2+i]) - int'(img[r-2][c-2+i]));
          end
          ax = (gx < 0) ? -gx : gx;
          ay = (gy < 0) ? -gy : gy;
          g  = ms ? ((ax > ay) ? ax : ay) : (ax + ay);
          exp_mag[r][c]  = g;
          exp_edge[r][c] = (g > thr);
          if (g > thr) n++;
        end
      end
    end
    return n;
  endfunction

  // One pixel clock: check outputs against inputs from LAT clocks ago, then drive.
  task automatic drive_cycle(input logic de, input logic hs, input logic vs,
                             input logic [7:0] d);
    logic [2:0] want;
    @(negedge clk);
    if (hist.size() == LAT) begin
      want = hist.pop_front();
      checks++;
      if ({sobel_de, sobel_hsync, sobel_vsync} !== want) begin
        errors++;
        $display("FAIL sync_delay got %b want %b", {sobel_de, sobel_hsync, sobel_vsync}, want);
      end
    end
    if (sobel_de === 1'b1) begin
      cap_data.push_back(sobel_data);
      cap_mag.push_back(sobel_mag);
    end else begin
      checks++;
      if (sobel_data !== 8'hFF || sobel_mag !== 11'd0) begin
        errors++;
        $display("FAIL idle_output got data %h mag %0d want data ff mag 0", sobel_data,
                 sobel_mag);
      end
    end
    Y_de    = de;
    Y_hsync = hs;
    Y_vsync = vs;
    Y_data  = d;
    hist.push_back({de, hs, vs});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic drive_line(input int r, input int npix);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);
    for (int c = 0; c < npix; c++) drive_cycle(1'b1, 1'b0, 1'b0, img[r][c]);
  endtask

  // Full frame; checks the previous frame's count and every pixel of this one.
  task automatic run_frame(input int thr, input bit op, input bit ms, input int chg,
                           output int cnt_prev);
    int n;
    logic [7:0] d;
    logic [10:0] m;
    cap_data.delete();
    cap_mag.delete();
    value   = 11'(thr);
    op_sel  = op;
    mag_sel = ms;
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (edge_cnt !== 20'(prev_exp)) begin
      errors++;
      $display("FAIL edge_cnt got %0d want %0d", edge_cnt, prev_exp);
    end
    cnt_prev = int'(edge_cnt);
    idle(3);
    for (int r = 0; r < int'(V); r++) begin
      if (r == 3 && chg >= 0) value = 11'(chg);
      drive_line(r, H);
      idle(4);
    end
    idle(8);
    n = model_frame(thr, op, ms);
    checks++;
    if (cap_data.size() != H * V) begin
      errors++;
      $display("FAIL pixel_count got %0d want %0d", cap_data.size(), H * V);
    end else begin
      for (int r = 0; r < int'(V); r++) begin
        for (int c = 0; c < int'(H); c++) begin
          d = cap_data.pop_front();
          m = cap_mag.pop_front();
          got_mag[r][c] = int'(m);
          checks++;
          if (d !== (exp_edge[r][c] ? 8'h00 : 8'hFF) || m !== 11'(exp_mag[r][c])) begin
            errors++;
            $display("FAIL pixel r%0d c%0d got data %h mag %0d want data %h mag %0d", r, c,
                     d, m, exp_edge[r][c] ? 8'h00 : 8'hFF, exp_mag[r][c]);
          end
        end
      end
    end
    prev_exp = n;
  endtask

  task automatic fill_step();
    for (int r = 0; r < int'(V); r++)
      for (int c = 0; c < int'(H); c++) img[r][c] = (c >= 10) ? 8'd255 : 8'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sobel_de, sobel_hsync, sobel_vsync} !== 3'b000 || sobel_data !== 8'h00 ||
        sobel_mag !== 11'd0 || edge_cnt !== 20'd0) begin
      errors++;
      $display("FAIL reset_state got de%b hs%b vs%b data %h mag %0d cnt %0d want all 0",
               sobel_de, sobel_hsync, sobel_vsync, sobel_data, sobel_mag, edge_cnt);
    end
    rst = 1'b0;
    idle(6);
  endtask

  task automatic test_flat();
    int c;
    for (int r = 0; r < int'(V); r++)
      for (int x = 0; x < int'(H); x++) img[r][x] = 8'h80;
    run_frame(10, 1'b0, 1'b0, -1, c);
    run_frame(10, 1'b0, 1'b0, -1, c);
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL flat_edge_cnt got %0d want 0", c);
    end
  endtask

  task automatic test_step_sobel();
    int c;
    fill_step();
    run_frame(100, 1'b0, 1'b0, -1, c);
    checks++;
    if (got_mag[2][10] != 1020 || got_mag[7][11] != 1020 || got_mag[4][12] != 0) begin
      errors++;
      $display("FAIL sobel_step_mag got %0d %0d %0d want 1020 1020 0", got_mag[2][10],
               got_mag[7][11], got_mag[4][12]);
    end
    run_frame(100, 1'b1, 1'b0, -1, c);
    checks++;
    if (c != 12) begin
      errors++;
      $display("FAIL sobel_step_cnt got %0d want 12", c);
    end
  endtask

  task automatic test_prewitt();
    int c;
    checks++;
    if (got_mag[3][10] != 765 || got_mag[5][11] != 765) begin
      errors++;
      $display("FAIL prewitt_mag got %0d %0d want 765 765", got_mag[3][10], got_mag[5][11]);
    end
    run_frame(800, 1'b1, 1'b0, -1, c);
    checks++;
    if (c != 12) begin
      errors++;
      $display("FAIL prewitt_cnt got %0d want 12", c);
    end
    run_frame(800, 1'b1, 1'b0, -1, c);
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL prewitt_high_thr_cnt got %0d want 0", c);
    end
  endtask

  task automatic test_diag_mag_sel();
    int c;
    for (int r = 0; r < int'(V); r++)
      for (int x = 0; x < int'(H); x++) img[r][x] = (x >= r + 5) ? 8'd220 : 8'd40;
    run_frame(300, 1'b0, 1'b1, -1, c);
    run_frame(300, 1'b0, 1'b0, -1, c);
    run_frame(300, 1'b1, 1'b1, -1, c);
  endtask

  task automatic test_mid_change();
    int c;
    fill_step();
    run_frame(100, 1'b0, 1'b0, 2000, c);
    run_frame(2000, 1'b0, 1'b0, -1, c);
    checks++;
    if (c != 12) begin
      errors++;
      $display("FAIL mid_change_cur_cnt got %0d want 12", c);
    end
    run_frame(2000, 1'b0, 1'b0, -1, c);
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL mid_change_next_cnt got %0d want 0", c);
    end
  endtask

  task automatic test_random();
    int c;
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < int'(V); r++)
        for (int x = 0; x < int'(H); x++) img[r][x] = 8'($urandom_range(0, 255));
      run_frame(int'($urandom_range(0, 1200)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, c);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    fill_step();
    run_frame(100, 1'b0, 1'b0, -1, c);
    value = 11'd100;
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    idle(3);
    for (int r = 0; r < 3; r++) begin
      drive_line(r, H);
      idle(4);
    end
    drive_line(3, 12);
    @(negedge clk);
    rst     = 1'b1;
    Y_de    = 1'b0;
    Y_hsync = 1'b0;
    Y_vsync = 1'b0;
    Y_data  = 8'h00;
    #1;
    checks++;
    if ({sobel_de, sobel_hsync, sobel_vsync} !== 3'b000 || sobel_data !== 8'h00 ||
        sobel_mag !== 11'd0 || edge_cnt !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_state got de%b hs%b vs%b data %h mag %0d cnt %0d want all 0",
               sobel_de, sobel_hsync, sobel_vsync, sobel_data, sobel_mag, edge_cnt);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    cap_data.delete();
    cap_mag.delete();
    prev_exp = 0;
    idle(3);
    run_frame(100, 1'b0, 1'b0, -1, c);
    run_frame(100, 1'b0, 1'b0, -1, c);
    checks++;
    if (c != 12) begin
      errors++;
      $display("FAIL reset_mid_recovery_cnt got %0d want 12", c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    Y_de    = 1'b0;
    Y_hsync = 1'b0;
    Y_vsync = 1'b0;
    Y_data  = '0;
    value   = '0;
    op_sel  = 1'b0;
    mag_sel = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_flat();
    test_step_sobel();
    test_prewitt();
    test_diag_mag_sel();
    test_mid_change();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
